circle_spawn_scheduler: RTL and testbench

CIRCLE_SPAWN_SCHEDULER -- requirements
Module: circle_spawn_scheduler

---
 rtl/circle_spawn_scheduler_pkg.sv | 32 +++
 rtl/hue_ramp.sv | 31 +++
 rtl/circle_spawn_scheduler.sv | 142 ++++++++++++++
 tb/tb_circle_spawn_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_spawn_scheduler_pkg.sv
// Shared visualizer definitions: scheduler FSM states, screen geometry and
// the breakpoints of the X-to-colour hue ramp.
package circle_spawn_scheduler_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int HUE_BP1 = 160;
  localparam int HUE_BP2 = 320;
  localparam int HUE_BP3 = 480;

  localparam logic [10:0] X_MAX = 11'(SCREEN_W - 1);
  localparam logic [10:0] Y_MAX = 11'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COLOR = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // 51/32 scales a 0..159 ramp distance onto 0..253; product kept at 19 bits.
  function automatic logic [7:0] ramp51(input logic [10:0] d);
    logic [18:0] p;
    p = 19'(d) * 19'd51;
    return 8'(p >> 5);
  endfunction

  function automatic logic [10:0] clamp_to(input logic [10:0] v, input logic [10:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/hue_ramp.sv
// Combinational X-position to RGB rainbow ramp (red -> green -> cyan -> blue).
// Expects X already clamped to the visible width.
module hue_ramp
  import circle_spawn_scheduler_pkg::*;
(
  input  logic [10:0] x,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  always_comb begin
    r = 8'd0;
    g = 8'd0;
    b = 8'd0;
    if (x < 11'(HUE_BP1)) begin
      r = 8'hFF;
      g = ramp51(x);
    end else if (x < 11'(HUE_BP2)) begin
      r = ramp51(11'(HUE_BP2 - 1) - x);
      g = 8'hFF;
    end else if (x < 11'(HUE_BP3)) begin
      g = 8'hFF;
      b = ramp51(x - 11'(HUE_BP2));
    end else begin
      g = ramp51(X_MAX - x);
      b = 8'hFF;
    end
  end

endmodule

// File: rtl/circle_spawn_scheduler.sv
// Arbitrates two spawn requesters, colours the accepted circle from its X
// position and writes it into the oldest circle-table slot; also emits fade ticks.
module circle_spawn_scheduler
  import circle_spawn_scheduler_pkg::*;
#(
  parameter int CIRNUM   = 25,
  parameter int FADE_DIV = 1048576,
  parameter int MIN_GAP  = 4194304
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [1:0]                i_req_valid,
  input  logic [1:0][10:0]          i_req_x,
  input  logic [1:0][10:0]          i_req_y,
  input  logic [1:0][10:0]          i_req_rad,
  output logic [1:0]                o_req_ready,
  output logic                      o_wr_en,
  output logic [$clog2(CIRNUM)-1:0] o_wr_slot,
  output logic [10:0]               o_wr_x,
  output logic [10:0]               o_wr_y,
  output logic [10:0]               o_wr_rad,
  output logic [7:0]                o_wr_r,
  output logic [7:0]                o_wr_g,
  output logic [7:0]                o_wr_b,
  output logic                      o_fade_tick,
  output logic                      o_busy,
  output state_t                    o_dbg_state
);

  localparam int SW = $clog2(CIRNUM);
  localparam int CW = $clog2(MIN_GAP + 1);
  localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(CIRNUM - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(MIN_GAP - 3);
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);

  state_t         state;
  logic [SW-1:0]  slot_ptr;
  logic [CW-1:0]  cooldown;
  logic [FW-1:0]  fade_cnt;
  logic           rr_prio;
  logic [10:0]    lat_x;
  logic [10:0]    lat_y;
  logic [10:0]    lat_rad;
  logic           win;
  logic           can_accept;
  logic           take;
  logic [7:0]     hue_r;
  logic [7:0]     hue_g;
  logic [7:0]     hue_b;

  // Handshake: a request transfers in the cycle where i_req_valid[k] and
  // o_req_ready[k] are both high; the requester holds valid and data stable
  // until then, and ready never depends on anything but state and valid.
  always_comb begin
    win = i_req_valid[1];
    if (i_req_valid == 2'b11) begin
      win = rr_prio;
    end
  end

  assign can_accept  = (state == ST_IDLE) && (cooldown == '0) && !i_rst;
  assign take        = can_accept && (i_req_valid != 2'b00);
  assign o_req_ready = take ? (win ? 2'b10 : 2'b01) : 2'b00;

  hue_ramp u_hue_ramp (
    .x (lat_x),
    .r (hue_r),
    .g (hue_g),
    .b (hue_b)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      slot_ptr  <= '0;
      cooldown  <= '0;
      rr_prio   <= 1'b0;
      lat_x     <= '0;
      lat_y     <= '0;
      lat_rad   <= '0;
      o_wr_en   <= 1'b0;
      o_wr_slot <= '0;
      o_wr_x    <= '0;
      o_wr_y    <= '0;
      o_wr_rad  <= '0;
      o_wr_r    <= '0;
      o_wr_g    <= '0;
      o_wr_b    <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            lat_x   <= clamp_to(i_req_x[win], X_MAX);
            lat_y   <= clamp_to(i_req_y[win], Y_MAX);
            lat_rad <= i_req_rad[win];
            rr_prio <= ~win;
            state   <= ST_COLOR;
          end
        end
        ST_COLOR: begin
          o_wr_en   <= 1'b1;
          o_wr_slot <= slot_ptr;
          o_wr_x    <= lat_x;
          o_wr_y    <= lat_y;
          o_wr_rad  <= lat_rad;
          o_wr_r    <= hue_r;
          o_wr_g    <= hue_g;
          o_wr_b    <= hue_b;
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          slot_ptr <= (slot_ptr == SLOT_LAST) ? '0 : slot_ptr + 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Loaded three short of the gap: handshake and COLOR cycles make up the rest.
      if (state == ST_WRITE) begin
        cooldown <= COOL_LOAD;
      end else if (cooldown != '0) begin
        cooldown <= cooldown - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fade_cnt <= '0;
    end else begin
      fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + 1'b1;
    end
  end

  assign o_fade_tick = (fade_cnt == FADE_LAST);
  assign o_busy      = (state != ST_IDLE) || (cooldown != '0);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_circle_spawn_scheduler.sv
// Directed bench for circle_spawn_scheduler: vector table of single spawns
// plus hand-written contention, fade, coincidence and reset-abort sequences.
module tb_circle_spawn_scheduler;
  import circle_spawn_scheduler_pkg::*;

  localparam int CIRNUM   = 4;
  localparam int FADE_DIV = 16;
  localparam int MIN_GAP  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid;
  logic [1:0][10:0] req_x;
  logic [1:0][10:0] req_y;
  logic [1:0][10:0] req_rad;
  logic [1:0]       o_req_ready;
  logic             o_wr_en;
  logic [1:0]       o_wr_slot;
  logic [10:0]      o_wr_x;
  logic [10:0]      o_wr_y;
  logic [10:0]      o_wr_rad;
  logic [7:0]       o_wr_r;
  logic [7:0]       o_wr_g;
  logic [7:0]       o_wr_b;
  logic             o_fade_tick;
  logic             o_busy;
  state_t           o_dbg_state;

  int n_tests;
  int n_fail;
  int cyc;

  logic [10:0] exp_q[$];

  typedef struct {
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] rad;
    logic [1:0]  slot;
    logic [10:0] ex;
    logic [10:0] ey;
    logic [7:0]  er;
    logic [7:0]  eg;
    logic [7:0]  eb;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  circle_spawn_scheduler #(
    .CIRNUM   (CIRNUM),
    .FADE_DIV (FADE_DIV),
    .MIN_GAP  (MIN_GAP)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_x     (req_x),
    .i_req_y     (req_y),
    .i_req_rad   (req_rad),
    .o_req_ready (o_req_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_slot   (o_wr_slot),
    .o_wr_x      (o_wr_x),
    .o_wr_y      (o_wr_y),
    .o_wr_rad    (o_wr_rad),
    .o_wr_r      (o_wr_r),
    .o_wr_g      (o_wr_g),
    .o_wr_b      (o_wr_b),
    .o_fade_tick (o_fade_tick),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int req, input int x, input int y, input int rad, input int slot,
                         input int ex, input int ey, input int r, input int g, input int b);
    vec_t v;
    v.req  = 1'(req);
    v.x    = 11'(x);
    v.y    = 11'(y);
    v.rad  = 11'(rad);
    v.slot = 2'(slot);
    v.ex   = 11'(ex);
    v.ey   = 11'(ey);
    v.er   = 8'(r);
    v.eg   = 8'(g);
    v.eb   = 8'(b);
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b01;
    req_x     = '0;
    req_y     = '0;
    req_rad   = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 32'(o_req_ready), 0);
    check("rst_wr_en", 32'(o_wr_en), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_fade", 32'(o_fade_tick), 0);
    check("rst_slot", 32'(o_wr_slot), 0);
    check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Returns at negedge+1 of the cycle after the write strobe.
  task automatic run_vec(input vec_t v);
    logic [1:0] exp_rdy;
    @(negedge clk);
    req_valid        = 2'b00;
    req_valid[v.req] = 1'b1;
    req_x[v.req]     = v.x;
    req_y[v.req]     = v.y;
    req_rad[v.req]   = v.rad;
    exp_rdy          = 2'b00;
    exp_rdy[v.req]   = 1'b1;
    #1;
    for (int t = 0; t < 40; t++) begin
      if (o_req_ready != 2'b00) break;
      @(negedge clk);
      #1;
    end
    check("accept", 32'(o_req_ready), 32'(exp_rdy));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("wr_en_t1", 32'(o_wr_en), 0);
    @(negedge clk);
    #1;
    check("wr_en_t2", 32'(o_wr_en), 1);
    check("wr_slot", 32'(o_wr_slot), 32'(v.slot));
    check("wr_x", 32'(o_wr_x), 32'(v.ex));
    check("wr_y", 32'(o_wr_y), 32'(v.ey));
    check("wr_rad", 32'(o_wr_rad), 32'(v.rad));
    check("wr_r", 32'(o_wr_r), 32'(v.er));
    check("wr_g", 32'(o_wr_g), 32'(v.eg));
    check("wr_b", 32'(o_wr_b), 32'(v.eb));
    @(negedge clk);
    #1;
    check("wr_en_t3", 32'(o_wr_en), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   writes;
    int   last_wr;
    int   wcount;
    logic exp_grant;
    vec_t v;

    n_tests = 0;
    n_fail  = 0;

    //       req    x    y   rad slot  ex   ey    r    g    b
    add_vec(0,   100, 200,   40, 0, 100, 200, 255, 159,   0);
    add_vec(1,   200, 479,    5, 1, 200, 479, 189, 255,   0);
    add_vec(0,   400, 500, 2047, 2, 400, 479,   0, 255, 127);
    add_vec(1,   639,   0,    0, 3, 639,   0,   0,   0, 255);
    add_vec(0,   700, 480,   10, 0, 639, 479,   0,   0, 255);
    add_vec(1,   160, 100,    1, 1, 160, 100, 253, 255,   0);
    add_vec(0,     0,   1,    2, 2,   0,   1, 255,   0,   0);
    add_vec(1,   320,   2,    3, 3, 320,   2,   0, 255,   0);
    add_vec(0,   480,   3,    4, 0, 480,   3,   0, 253, 255);
    add_vec(1,   159,   4,    5, 1, 159,   4, 255, 253,   0);
    add_vec(0,   319,   5,    6, 2, 319,   5,   0, 255,   0);
    add_vec(1,  2047, 2047,   7, 3, 639, 479,   0,   0, 255);

    do_reset();
    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: both requesters held valid; grants alternate, writes 8 apart.
    do_reset();
    req_x[0] = 11'd10;  req_y[0] = 11'd20; req_rad[0] = 11'd3;
    req_x[1] = 11'd600; req_y[1] = 11'd30; req_rad[1] = 11'd4;
    req_valid = 2'b11;
    #1;
    exp_grant = 1'b0;
    writes    = 0;
    last_wr   = -1;
    for (int c = 0; c < 60 && writes < 4; c++) begin
      if (o_req_ready != 2'b00) begin
        check("cont_grant", 32'(o_req_ready), exp_grant ? 32'd2 : 32'd1);
        exp_q.push_back(exp_grant ? 11'd600 : 11'd10);
        exp_grant = ~exp_grant;
      end
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cont_unexpected_write: got write at cycle %0d, want none", cyc);
        end else begin
          check("cont_wr_x", 32'(o_wr_x), 32'(exp_q.pop_front()));
        end
        if (last_wr >= 0) check("cont_gap", 32'(cyc - last_wr), 32'(MIN_GAP));
        last_wr = cyc;
        writes++;
      end
      @(negedge clk);
      #1;
    end
    check("cont_writes", 32'(writes), 4);
    req_valid = 2'b00;

    // Fade ticks with no spawns: cycles 15, 31, 47 only.
    do_reset();
    for (int c = 0; c <= 48; c++) begin
      check("fade_tick", 32'(o_fade_tick), (c % 16 == 15) ? 32'd1 : 32'd0);
      @(negedge clk);
      #1;
    end

    // Write timed to land on the cycle-15 fade tick.
    do_reset();
    repeat (13) @(negedge clk);
    req_x[0] = 11'd100; req_y[0] = 11'd10; req_rad[0] = 11'd9;
    req_valid = 2'b01;
    #1;
    check("coin_accept", 32'(o_req_ready), 1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    check("coin_wr_en", 32'(o_wr_en), 1);
    check("coin_fade", 32'(o_fade_tick), 1);

    // Reset abort: slot pointer moved to 1, then reset in COLOR.
    do_reset();
    add_vec(0, 50, 60, 7, 0, 50, 60, 255, 79, 0);
    v = vecs[vecs.size() - 1];
    run_vec(v);
    @(negedge clk);
    req_x[0] = 11'd300; req_y[0] = 11'd40; req_rad[0] = 11'd8;
    req_valid = 2'b01;
    #1;
    for (int t = 0; t < 40; t++) begin
      if (o_req_ready != 2'b00) break;
      @(negedge clk);
      #1;
    end
    check("abort_accept", 32'(o_req_ready), 1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("abort_in_color", 32'(o_dbg_state), 32'(ST_COLOR));
    rst = 1'b1;
    #1;
    check("abort_state", 32'(o_dbg_state), 32'(ST_IDLE));
    check("abort_wr_en", 32'(o_wr_en), 0);
    check("abort_busy", 32'(o_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    wcount = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      #1;
      if (o_wr_en) wcount++;
    end
    check("abort_no_write", 32'(wcount), 0);
    add_vec(1, 50, 60, 7, 0, 50, 60, 255, 79, 0);
    v = vecs[vecs.size() - 1];
    run_vec(v);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by t=%0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
